// File: rtl/change_dispense_ctrl.sv
// Change dispenser controller: evaluates a payment against a cost and, when
// change is owed, hands out coins greedily (quarter, dime, nickel) through a
// valid/ready ejector handshake while tracking a small coin inventory.
module change_dispense_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] Cost,
    input  logic [3:0] Paid,
    input  logic       load,
    input  logic [1:0] LoadQuarters,
    input  logic [1:0] LoadDimes,
    input  logic [1:0] LoadNickels,
    output logic       CoinValid,
    output logic [2:0] CoinValue,
    input  logic       CoinReady,
    output logic [1:0] Quarters,
    output logic [1:0] Dimes,
    output logic [1:0] Nickels,
    output logic [2:0] FirstCoin,
    output logic [2:0] SecondCoin,
    output logic [3:0] Remaining,
    output logic       Busy,
    output logic       Done,
    output logic       ExactAmmount,
    output logic       CoughUpMore,
    output logic       NotEnoughChange
);

    localparam logic [2:0] COIN_NONE    = 3'b000;
    localparam logic [2:0] COIN_NICKEL  = 3'b001;
    localparam logic [2:0] COIN_DIME    = 3'b010;
    localparam logic [2:0] COIN_QUARTER = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVAL     = 2'd1,
        DISPENSE = 2'd2,
        FINISH   = 2'd3
    } state_t;

    state_t     state, state_nxt;

    logic [3:0] cost_q, paid_q;
    logic [3:0] cost_nxt, paid_nxt;
    logic [3:0] rem_nxt;
    logic [1:0] q_nxt, d_nxt, n_nxt;
    logic [2:0] first_nxt, second_nxt;
    logic       vld_nxt;
    logic [2:0] val_nxt;
    logic       exact_nxt, cough_nxt, nec_nxt;
    logic       handshake;

    // Nickel worth of a coin code; unknown codes are worth nothing.
    function automatic logic [3:0] coin_worth(input logic [2:0] code);
        case (code)
            COIN_QUARTER: coin_worth = 4'd5;
            COIN_DIME:    coin_worth = 4'd2;
            COIN_NICKEL:  coin_worth = 4'd1;
            default:      coin_worth = 4'd0;
        endcase
    endfunction

    assign handshake = (state == DISPENSE) && CoinValid && CoinReady;
    assign Busy      = (state != IDLE);
    assign Done      = (state == FINISH);

    // State register; reset forces IDLE immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-value logic for every state-held quantity.
    always_comb begin
        state_nxt  = state;
        cost_nxt   = cost_q;
        paid_nxt   = paid_q;
        rem_nxt    = Remaining;
        q_nxt      = Quarters;
        d_nxt      = Dimes;
        n_nxt      = Nickels;
        first_nxt  = FirstCoin;
        second_nxt = SecondCoin;
        vld_nxt    = CoinValid;
        val_nxt    = CoinValue;
        exact_nxt  = ExactAmmount;
        cough_nxt  = CoughUpMore;
        nec_nxt    = NotEnoughChange;

        case (state)
            IDLE: begin
                vld_nxt = 1'b0;
                if (start) begin
                    // start has priority over a simultaneous restock
                    cost_nxt   = Cost;
                    paid_nxt   = Paid;
                    rem_nxt    = 4'd0;
                    first_nxt  = COIN_NONE;
                    second_nxt = COIN_NONE;
                    exact_nxt  = 1'b0;
                    cough_nxt  = 1'b0;
                    nec_nxt    = 1'b0;
                    state_nxt  = EVAL;
                end else if (load) begin
                    q_nxt = LoadQuarters;
                    d_nxt = LoadDimes;
                    n_nxt = LoadNickels;
                end
            end

            EVAL: begin
                if (paid_q == cost_q) begin
                    exact_nxt = 1'b1;
                    rem_nxt   = 4'd0;
                    state_nxt = FINISH;
                end else if (paid_q < cost_q) begin
                    cough_nxt = 1'b1;
                    rem_nxt   = 4'd0;
                    state_nxt = FINISH;
                end else begin
                    rem_nxt   = paid_q - cost_q;
                    state_nxt = DISPENSE;
                end
            end

            DISPENSE: begin
                if (!CoinValid) begin
                    // select cycle: largest coin that fits and is in stock
                    if (Remaining == 4'd0) begin
                        nec_nxt   = 1'b0;
                        state_nxt = FINISH;
                    end else if ((Quarters != 2'd0) && (Remaining >= 4'd5)) begin
                        vld_nxt = 1'b1;
                        val_nxt = COIN_QUARTER;
                    end else if ((Dimes != 2'd0) && (Remaining >= 4'd2)) begin
                        vld_nxt = 1'b1;
                        val_nxt = COIN_DIME;
                    end else if (Nickels != 2'd0) begin
                        vld_nxt = 1'b1;
                        val_nxt = COIN_NICKEL;
                    end else begin
                        nec_nxt   = 1'b1;
                        state_nxt = FINISH;
                    end
                end else if (handshake) begin
                    // coin accepted by the ejector: book it and reselect
                    vld_nxt = 1'b0;
                    rem_nxt = Remaining - coin_worth(CoinValue);
                    case (CoinValue)
                        COIN_QUARTER: if (Quarters != 2'd0) q_nxt = Quarters - 2'd1;
                        COIN_DIME:    if (Dimes != 2'd0)    d_nxt = Dimes - 2'd1;
                        COIN_NICKEL:  if (Nickels != 2'd0)  n_nxt = Nickels - 2'd1;
                        default:      ;
                    endcase
                    if (FirstCoin == COIN_NONE) begin
                        first_nxt = CoinValue;
                    end else if (SecondCoin == COIN_NONE) begin
                        second_nxt = CoinValue;
                    end
                end
            end

            FINISH: begin
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end

            default: begin
                vld_nxt   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath, inventory and status registers; reset clears them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cost_q          <= 4'd0;
            paid_q          <= 4'd0;
            Remaining       <= 4'd0;
            Quarters        <= 2'd0;
            Dimes           <= 2'd0;
            Nickels         <= 2'd0;
            FirstCoin       <= COIN_NONE;
            SecondCoin      <= COIN_NONE;
            CoinValid       <= 1'b0;
            CoinValue       <= COIN_NONE;
            ExactAmmount    <= 1'b0;
            CoughUpMore     <= 1'b0;
            NotEnoughChange <= 1'b0;
        end else begin
            cost_q          <= cost_nxt;
            paid_q          <= paid_nxt;
            Remaining       <= rem_nxt;
            Quarters        <= q_nxt;
            Dimes           <= d_nxt;
            Nickels         <= n_nxt;
            FirstCoin       <= first_nxt;
            SecondCoin      <= second_nxt;
            CoinValid       <= vld_nxt;
            CoinValue       <= val_nxt;
            ExactAmmount    <= exact_nxt;
            CoughUpMore     <= cough_nxt;
            NotEnoughChange <= nec_nxt;
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Directed bench for change_dispense_ctrl: restock, full change, greedy
// shortfall, exact and short payment, ejector stall, and async reset.
module tb_change_dispense_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] Cost;
    logic [3:0] Paid;
    logic       load;
    logic [1:0] LoadQuarters;
    logic [1:0] LoadDimes;
    logic [1:0] LoadNickels;
    logic       CoinValid;
    logic [2:0] CoinValue;
    logic       CoinReady;
    logic [1:0] Quarters;
    logic [1:0] Dimes;
    logic [1:0] Nickels;
    logic [2:0] FirstCoin;
    logic [2:0] SecondCoin;
    logic [3:0] Remaining;
    logic       Busy;
    logic       Done;
    logic       ExactAmmount;
    logic       CoughUpMore;
    logic       NotEnoughChange;

    int npass;
    int ntotal;

    change_dispense_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .Cost            (Cost),
        .Paid            (Paid),
        .load            (load),
        .LoadQuarters    (LoadQuarters),
        .LoadDimes       (LoadDimes),
        .LoadNickels     (LoadNickels),
        .CoinValid       (CoinValid),
        .CoinValue       (CoinValue),
        .CoinReady       (CoinReady),
        .Quarters        (Quarters),
        .Dimes           (Dimes),
        .Nickels         (Nickels),
        .FirstCoin       (FirstCoin),
        .SecondCoin      (SecondCoin),
        .Remaining       (Remaining),
        .Busy            (Busy),
        .Done            (Done),
        .ExactAmmount    (ExactAmmount),
        .CoughUpMore     (CoughUpMore),
        .NotEnoughChange (NotEnoughChange)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        npass        = 0;
        ntotal       = 0;
        reset        = 1'b0;
        start        = 1'b0;
        Cost         = 4'd0;
        Paid         = 4'd0;
        load         = 1'b0;
        LoadQuarters = 2'd0;
        LoadDimes    = 2'd0;
        LoadNickels  = 2'd0;
        CoinReady    = 1'b0;

        // reset state, checked before any clock edge
        #2 reset = 1'b1;
        #1;
        check("rst_busy",  {7'd0, Busy},      8'd0);
        check("rst_valid", {7'd0, CoinValid}, 8'd0);
        check("rst_done",  {7'd0, Done},      8'd0);
        check("rst_q",     {6'd0, Quarters},  8'd0);
        check("rst_rem",   {4'd0, Remaining}, 8'd0);
        check("rst_first", {5'd0, FirstCoin}, 8'd0);
        tick();
        tick();
        reset = 1'b0;

        // full change: Q1 D1 N3, cost 3 paid 11 -> 8 nickels owed
        load = 1'b1; LoadQuarters = 2'd1; LoadDimes = 2'd1; LoadNickels = 2'd3;
        tick();
        load = 1'b0;
        check("ld_q", {6'd0, Quarters}, 8'd1);
        check("ld_d", {6'd0, Dimes},    8'd1);
        check("ld_n", {6'd0, Nickels},  8'd3);
        check("ld_busy", {7'd0, Busy},  8'd0);
        start = 1'b1; Cost = 4'd3; Paid = 4'd11; CoinReady = 1'b1;
        tick();                                   // EVAL
        start = 1'b0;
        check("a_eval_busy",  {7'd0, Busy},      8'd1);
        check("a_eval_done",  {7'd0, Done},      8'd0);
        tick();                                   // DISPENSE select
        check("a_rem8",       {4'd0, Remaining}, 8'd8);
        check("a_sel_valid",  {7'd0, CoinValid}, 8'd0);
        tick();
        check("a_c1_valid",   {7'd0, CoinValid}, 8'd1);
        check("a_c1_value",   {5'd0, CoinValue}, 8'h05);
        check("a_c1_done",    {7'd0, Done},      8'd0);
        tick();                                   // quarter accepted
        check("a_hs1_valid",  {7'd0, CoinValid}, 8'd0);
        check("a_hs1_q",      {6'd0, Quarters},  8'd0);
        check("a_hs1_rem",    {4'd0, Remaining}, 8'd3);
        check("a_hs1_first",  {5'd0, FirstCoin}, 8'h05);
        tick();
        check("a_c2_value",   {5'd0, CoinValue}, 8'h02);
        tick();                                   // dime accepted
        check("a_hs2_d",      {6'd0, Dimes},     8'd0);
        check("a_hs2_rem",    {4'd0, Remaining}, 8'd1);
        check("a_hs2_second", {5'd0, SecondCoin},8'h02);
        tick();
        check("a_c3_value",   {5'd0, CoinValue}, 8'h01);
        tick();                                   // nickel accepted
        check("a_hs3_n",      {6'd0, Nickels},   8'd2);
        check("a_hs3_rem",    {4'd0, Remaining}, 8'd0);
        check("a_hs3_first",  {5'd0, FirstCoin}, 8'h05);
        tick();                                   // FINISH
        check("a_done",       {7'd0, Done},      8'd1);
        check("a_nec",        {7'd0, NotEnoughChange}, 8'd0);
        tick();                                   // back to IDLE, results hold
        check("a_idle_done",  {7'd0, Done},      8'd0);
        check("a_idle_busy",  {7'd0, Busy},      8'd0);
        check("a_hold_first", {5'd0, FirstCoin}, 8'h05);
        check("a_hold_second",{5'd0, SecondCoin},8'h02);

        // greedy shortfall: Q1 D3 N0, cost 0 paid 6 -> quarter then stuck at 1
        load = 1'b1; LoadQuarters = 2'd1; LoadDimes = 2'd3; LoadNickels = 2'd0;
        tick();
        load = 1'b0;
        start = 1'b1; Cost = 4'd0; Paid = 4'd6;
        tick();                                   // EVAL
        start = 1'b0;
        check("b_clr_first",  {5'd0, FirstCoin}, 8'd0);
        tick();                                   // DISPENSE select
        check("b_rem6",       {4'd0, Remaining}, 8'd6);
        tick();
        check("b_c1_value",   {5'd0, CoinValue}, 8'h05);
        tick();                                   // quarter accepted
        check("b_hs_rem",     {4'd0, Remaining}, 8'd1);
        tick();                                   // nothing fits -> FINISH
        check("b_done",       {7'd0, Done},      8'd1);
        check("b_nec",        {7'd0, NotEnoughChange}, 8'd1);
        check("b_no_valid",   {7'd0, CoinValid}, 8'd0);
        tick();
        check("b_rem_keep",   {4'd0, Remaining}, 8'd1);
        check("b_q",          {6'd0, Quarters},  8'd0);
        check("b_d",          {6'd0, Dimes},     8'd3);
        check("b_n",          {6'd0, Nickels},   8'd0);
        check("b_second",     {5'd0, SecondCoin},8'd0);
        check("b_nec_hold",   {7'd0, NotEnoughChange}, 8'd1);

        // exact payment
        start = 1'b1; Cost = 4'd7; Paid = 4'd7;
        tick();                                   // EVAL
        start = 1'b0;
        check("c_nec_clr",    {7'd0, NotEnoughChange}, 8'd0);
        check("c_rem_clr",    {4'd0, Remaining}, 8'd0);
        check("c_eval_done",  {7'd0, Done},      8'd0);
        tick();
        check("c_done",       {7'd0, Done},      8'd1);
        check("c_exact",      {7'd0, ExactAmmount}, 8'd1);
        check("c_no_valid",   {7'd0, CoinValid}, 8'd0);
        tick();
        check("c_idle_done",  {7'd0, Done},      8'd0);
        check("c_exact_hold", {7'd0, ExactAmmount}, 8'd1);

        // short payment
        start = 1'b1; Cost = 4'd9; Paid = 4'd4;
        tick();
        start = 1'b0;
        check("d_exact_clr",  {7'd0, ExactAmmount}, 8'd0);
        tick();
        check("d_done",       {7'd0, Done},      8'd1);
        check("d_cough",      {7'd0, CoughUpMore}, 8'd1);
        check("d_exact",      {7'd0, ExactAmmount}, 8'd0);
        tick();

        // ejector stall: Q0 D2 N1, cost 1 paid 4 -> dime held while not ready
        load = 1'b1; LoadQuarters = 2'd0; LoadDimes = 2'd2; LoadNickels = 2'd1;
        tick();
        load = 1'b0;
        CoinReady = 1'b0;
        start = 1'b1; Cost = 4'd1; Paid = 4'd4;
        tick();                                   // EVAL
        start = 1'b0;
        tick();                                   // DISPENSE select
        tick();
        check("e_c1_valid",   {7'd0, CoinValid}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("e_stall_valid", {7'd0, CoinValid}, 8'd1);
            check("e_stall_value", {5'd0, CoinValue}, 8'h02);
            check("e_stall_d",     {6'd0, Dimes},     8'd2);
        end
        CoinReady = 1'b1;
        tick();                                   // dime accepted once
        CoinReady = 1'b0;
        check("e_hs_d",       {6'd0, Dimes},     8'd1);
        check("e_hs_rem",     {4'd0, Remaining}, 8'd1);
        check("e_hs_valid",   {7'd0, CoinValid}, 8'd0);
        tick();
        check("e_c2_value",   {5'd0, CoinValue}, 8'h01);
        check("e_c2_valid",   {7'd0, CoinValid}, 8'd1);

        // start/load during DISPENSE are ignored
        start = 1'b1; load = 1'b1; LoadQuarters = 2'd3; LoadDimes = 2'd3; LoadNickels = 2'd3;
        Cost = 4'd0; Paid = 4'd0;
        tick();
        start = 1'b0; load = 1'b0;
        check("f_ign_q",      {6'd0, Quarters},  8'd0);
        check("f_ign_d",      {6'd0, Dimes},     8'd1);
        check("f_ign_n",      {6'd0, Nickels},   8'd1);
        check("f_ign_valid",  {7'd0, CoinValid}, 8'd1);
        check("f_ign_busy",   {7'd0, Busy},      8'd1);
        check("f_ign_rem",    {4'd0, Remaining}, 8'd1);

        // async reset mid-cycle while a coin is presented
        #3 reset = 1'b1;
        #1;
        check("g_rst_valid",  {7'd0, CoinValid}, 8'd0);
        check("g_rst_busy",   {7'd0, Busy},      8'd0);
        check("g_rst_n",      {6'd0, Nickels},   8'd0);
        check("g_rst_d",      {6'd0, Dimes},     8'd0);
        check("g_rst_first",  {5'd0, FirstCoin}, 8'd0);
        check("g_rst_rem",    {4'd0, Remaining}, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        check("g_post_busy",  {7'd0, Busy},      8'd0);
        check("g_post_valid", {7'd0, CoinValid}, 8'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
